// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Moore-style main controller for the multicycle MIPS-lite datapath. It
//   sequences one instruction over 3-5 cycles, plus one extra cycle for every
//   cycle in which memory is not ready.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   opcode       in   IR opcode field, stable from DECODE onward
//   mem_ready    in   memory access completes this cycle
//   pcwrite      out  unconditional PC load
//   pcwritecond  out  PC load qualified by the branch condition
//   brtype       out  branch condition: 00 zero, 01 rs<0, 10 N flag
//   pcsource     out  PC source: 00 ALU, 01 ALUOut, 10 jump target
//   iord         out  memory address: 0 PC, 1 ALUOut
//   memread      out  memory read strobe
//   memwrite     out  memory write strobe
//   memdata_link out  memory write data is PC instead of register B
//   irwrite      out  instruction register load
//   memtoreg     out  register write data from MDR
//   regdst       out  register destination: 1 rd, 0 rt
//   regwrite     out  register file write
//   linkwrite    out  write PC to $31
//   alusrca      out  ALU A: 0 PC, 1 register A
//   alusrcb      out  ALU B: 00 B, 01 4, 10 imm, 11 imm<<2
//   zeroext      out  zero-extend the immediate
//   aluop        out  00 add, 01 sub, 10 funct, 11 or
//   illegal_op   out  one-cycle pulse on an undecodable opcode
//   instr_count  out  retired-instruction count (wraps)
// ----------------------------------------------------------------------------
module multicycle_control #(
  parameter int         CNT_W         = 16,
  parameter bit         MEM_HANDSHAKE = 1'b1,
  parameter logic [5:0] OP_LW         = 6'd35,
  parameter logic [5:0] OP_SW         = 6'd43,
  parameter logic [5:0] OP_BEQ        = 6'd4,
  parameter logic [5:0] OP_J          = 6'd2,
  parameter logic [5:0] OP_ORI        = 6'd13,
  parameter logic [5:0] OP_BLTZAL     = 6'd34,
  parameter logic [5:0] OP_JSPAL      = 6'd19,
  parameter logic [5:0] OP_BALN       = 6'd27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic [1:0]       brtype,
  output logic [1:0]       pcsource,
  output logic             iord,
  output logic             memread,
  output logic             memwrite,
  output logic             memdata_link,
  output logic             irwrite,
  output logic             memtoreg,
  output logic             regdst,
  output logic             regwrite,
  output logic             linkwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             zeroext,
  output logic [1:0]       aluop,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_RWB, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_JSPWR, S_BEQ, S_BLTZ, S_BALN, S_JUMP, S_ORIEX, S_ORIWB
  } state_t;

  state_t state, next_state;
  logic   rdy;
  logic   retire;   // this edge completes an instruction
  logic   bad_op;   // DECODE saw an opcode outside the map

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // Next-state logic. Any encoding outside the enum falls back to FETCH.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    next_state = S_FETCH;
    retire     = 1'b0;
    bad_op     = 1'b0;
    case (state)
      S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          6'd0:                    next_state = S_EXEC;
          OP_LW, OP_SW, OP_JSPAL:  next_state = S_MEMADR;
          OP_BEQ:                  next_state = S_BEQ;
          OP_J:                    next_state = S_JUMP;
          OP_ORI:                  next_state = S_ORIEX;
          OP_BLTZAL:               next_state = S_BLTZ;
          OP_BALN:                 next_state = S_BALN;
          default: begin
            next_state = S_FETCH;
            bad_op     = 1'b1;
          end
        endcase
      end
      S_EXEC:   next_state = S_RWB;
      S_MEMADR: begin
        if (opcode == OP_LW)         next_state = S_MEMRD;
        else if (opcode == OP_SW)    next_state = S_MEMWR;
        else if (opcode == OP_JSPAL) next_state = S_JSPWR;
        else                         next_state = S_FETCH;
      end
      S_MEMRD:  next_state = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        next_state = rdy ? S_FETCH : S_MEMWR;
        retire     = rdy;
      end
      S_JSPWR:  next_state = rdy ? S_JUMP : S_JSPWR;
      S_ORIEX:  next_state = S_ORIWB;
      S_RWB, S_MEMWB, S_BEQ, S_BLTZ, S_BALN, S_JUMP, S_ORIWB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      default:  next_state = S_FETCH;
    endcase
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    if (reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Output decode. Reset gates everything combinationally so an asserted
  // reset kills strobes immediately, not at the next edge.
  always_comb begin
    pcwrite      = 1'b0;
    pcwritecond  = 1'b0;
    brtype       = 2'b00;
    pcsource     = 2'b00;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    memdata_link = 1'b0;
    irwrite      = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite     = 1'b0;
    linkwrite    = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    zeroext      = 1'b0;
    aluop        = 2'b00;
    illegal_op   = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          memread = 1'b1;
          alusrcb = 2'b01;
          // IR and PC load only on the cycle the fetch actually completes.
          irwrite = rdy;
          pcwrite = rdy;
        end
        S_DECODE: begin
          alusrcb    = 2'b11;
          illegal_op = bad_op;
        end
        S_EXEC: begin
          alusrca = 1'b1;
          aluop   = 2'b10;
        end
        S_RWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: begin
          iord    = 1'b1;
          memread = 1'b1;
        end
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_JSPWR: begin
          iord         = 1'b1;
          memwrite     = 1'b1;
          memdata_link = 1'b1;
        end
        S_BEQ: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          pcsource    = 2'b01;
        end
        S_BLTZ: begin
          alusrca     = 1'b1;
          aluop       = 2'b01;
          pcwritecond = 1'b1;
          brtype      = 2'b01;
          pcsource    = 2'b01;
          linkwrite   = 1'b1;   // link is written whether or not the branch is taken
        end
        S_BALN: begin
          pcwritecond = 1'b1;
          brtype      = 2'b10;
          pcsource    = 2'b01;
          linkwrite   = 1'b1;
        end
        S_JUMP: begin
          pcwrite  = 1'b1;
          pcsource = 2'b10;
        end
        S_ORIEX: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          zeroext = 1'b1;
          aluop   = 2'b11;
        end
        S_ORIWB: regwrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control with CNT_W=2 so counter wrap is
//   reached quickly. Outputs are packed into one vector and compared per cycle
//   on the falling edge against hand-built per-state constants.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memdata_link;
  logic       irwrite, memtoreg, regdst, regwrite, linkwrite, alusrca;
  logic       zeroext, illegal_op;
  logic [1:0] brtype, pcsource, alusrcb, aluop;
  logic [1:0] instr_count;

  int checks   = 0;
  int failures = 0;

  multicycle_control #(.CNT_W(2), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .brtype(brtype),
    .pcsource(pcsource), .iord(iord), .memread(memread), .memwrite(memwrite),
    .memdata_link(memdata_link), .irwrite(irwrite), .memtoreg(memtoreg),
    .regdst(regdst), .regwrite(regwrite), .linkwrite(linkwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext), .aluop(aluop),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Packed view of every control output (bit 21 down to bit 0).
  logic [21:0] obs;
  assign obs = {pcwrite, pcwritecond, brtype, pcsource, iord, memread,
                memwrite, memdata_link, irwrite, memtoreg, regdst, regwrite,
                linkwrite, alusrca, alusrcb, zeroext, aluop, illegal_op};

  localparam logic [21:0] B_PCW   = 22'd1 << 21;
  localparam logic [21:0] B_PCWC  = 22'd1 << 20;
  localparam logic [21:0] BR_NEG  = 22'd1 << 18;
  localparam logic [21:0] BR_N    = 22'd2 << 18;
  localparam logic [21:0] PCS_AO  = 22'd1 << 16;
  localparam logic [21:0] PCS_J   = 22'd2 << 16;
  localparam logic [21:0] B_IORD  = 22'd1 << 15;
  localparam logic [21:0] B_MRD   = 22'd1 << 14;
  localparam logic [21:0] B_MWR   = 22'd1 << 13;
  localparam logic [21:0] B_LINKD = 22'd1 << 12;
  localparam logic [21:0] B_IRW   = 22'd1 << 11;
  localparam logic [21:0] B_M2R   = 22'd1 << 10;
  localparam logic [21:0] B_RDST  = 22'd1 << 9;
  localparam logic [21:0] B_RW    = 22'd1 << 8;
  localparam logic [21:0] B_LW31  = 22'd1 << 7;
  localparam logic [21:0] B_SRCA  = 22'd1 << 6;
  localparam logic [21:0] SRCB_4  = 22'd1 << 4;
  localparam logic [21:0] SRCB_I  = 22'd2 << 4;
  localparam logic [21:0] SRCB_SH = 22'd3 << 4;
  localparam logic [21:0] B_ZEXT  = 22'd1 << 3;
  localparam logic [21:0] ALU_SUB = 22'd1 << 1;
  localparam logic [21:0] ALU_FN  = 22'd2 << 1;
  localparam logic [21:0] ALU_OR  = 22'd3 << 1;
  localparam logic [21:0] B_ILL   = 22'd1;

  localparam logic [21:0] E_FETCH   = B_MRD | SRCB_4 | B_IRW | B_PCW;
  localparam logic [21:0] E_FSTALL  = B_MRD | SRCB_4;
  localparam logic [21:0] E_DECODE  = SRCB_SH;
  localparam logic [21:0] E_DEC_ILL = SRCB_SH | B_ILL;
  localparam logic [21:0] E_EXEC    = B_SRCA | ALU_FN;
  localparam logic [21:0] E_RWB     = B_RDST | B_RW;
  localparam logic [21:0] E_MEMADR  = B_SRCA | SRCB_I;
  localparam logic [21:0] E_MEMRD   = B_IORD | B_MRD;
  localparam logic [21:0] E_MEMWB   = B_M2R | B_RW;
  localparam logic [21:0] E_MEMWR   = B_IORD | B_MWR;
  localparam logic [21:0] E_JSPWR   = B_IORD | B_MWR | B_LINKD;
  localparam logic [21:0] E_BEQ     = B_SRCA | ALU_SUB | B_PCWC | PCS_AO;
  localparam logic [21:0] E_BLTZ    = B_SRCA | ALU_SUB | B_PCWC | BR_NEG | PCS_AO | B_LW31;
  localparam logic [21:0] E_BALN    = B_PCWC | BR_N | PCS_AO | B_LW31;
  localparam logic [21:0] E_JUMP    = B_PCW | PCS_J;
  localparam logic [21:0] E_ORIEX   = B_SRCA | SRCB_I | B_ZEXT | ALU_OR;
  localparam logic [21:0] E_ORIWB   = B_RW;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // One clock: compare outputs mid-cycle, then step past the next rising edge.
  task automatic cyc(input string tag, input logic [21:0] expected);
    @(negedge clk);
    check(tag, {10'd0, obs}, {10'd0, expected});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 6'd0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs", {10'd0, obs}, 32'd0);
    check("reset_count", {30'd0, instr_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R-type: 4 cycles, count 0 -> 1
    cyc("r_fetch", E_FETCH);
    cyc("r_decode", E_DECODE);
    cyc("r_exec", E_EXEC);
    cyc("r_rwb", E_RWB);
    check("r_count", {30'd0, instr_count}, 32'd1);

    // lw with two stall cycles in MEMRD: 7 cycles, count -> 2
    opcode = 6'd35;
    cyc("lw_fetch", E_FETCH);
    cyc("lw_decode", E_DECODE);
    cyc("lw_memadr", E_MEMADR);
    mem_ready = 1'b0;
    cyc("lw_memrd_stall1", E_MEMRD);
    cyc("lw_memrd_stall2", E_MEMRD);
    mem_ready = 1'b1;
    cyc("lw_memrd_done", E_MEMRD);
    cyc("lw_memwb", E_MEMWB);
    check("lw_count", {30'd0, instr_count}, 32'd2);

    // jspal: 5 cycles, count -> 3
    opcode = 6'd19;
    cyc("jspal_fetch", E_FETCH);
    cyc("jspal_decode", E_DECODE);
    cyc("jspal_memadr", E_MEMADR);
    cyc("jspal_jspwr", E_JSPWR);
    cyc("jspal_jump", E_JUMP);
    check("jspal_count", {30'd0, instr_count}, 32'd3);

    // bltzal then baln: 3 cycles each; count wraps 3 -> 0 -> 1
    opcode = 6'd34;
    cyc("bltzal_fetch", E_FETCH);
    cyc("bltzal_decode", E_DECODE);
    cyc("bltzal_bltz", E_BLTZ);
    check("bltzal_count_wrap", {30'd0, instr_count}, 32'd0);
    opcode = 6'd27;
    cyc("baln_fetch", E_FETCH);
    cyc("baln_decode", E_DECODE);
    cyc("baln_baln", E_BALN);
    check("baln_count", {30'd0, instr_count}, 32'd1);

    // Illegal opcode: pulse in DECODE only, back to FETCH, no retire
    opcode = 6'd63;
    cyc("ill_fetch", E_FETCH);
    cyc("ill_decode", E_DEC_ILL);
    check("ill_count", {30'd0, instr_count}, 32'd1);

    // FETCH stall for 3 cycles, then a complete sw: count -> 2
    opcode    = 6'd43;
    mem_ready = 1'b0;
    cyc("fstall_1", E_FSTALL);
    cyc("fstall_2", E_FSTALL);
    cyc("fstall_3", E_FSTALL);
    mem_ready = 1'b1;
    cyc("sw_fetch", E_FETCH);
    cyc("sw_decode", E_DECODE);
    cyc("sw_memadr", E_MEMADR);
    cyc("sw_memwr", E_MEMWR);
    check("sw_count", {30'd0, instr_count}, 32'd2);

    // Second sw aborted by an asynchronous reset while stalled in MEMWR
    cyc("swr_fetch", E_FETCH);
    cyc("swr_decode", E_DECODE);
    cyc("swr_memadr", E_MEMADR);
    mem_ready = 1'b0;
    @(negedge clk);
    check("swr_memwr_before_reset", {10'd0, obs}, {10'd0, E_MEMWR});
    #2;
    reset = 1'b1;
    #1;
    check("swr_outputs_in_reset", {10'd0, obs}, 32'd0);
    check("swr_count_in_reset", {30'd0, instr_count}, 32'd0);
    @(posedge clk);
    #1;
    check("swr_outputs_reset_edge", {10'd0, obs}, 32'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;

    // beq (3), ori (4), j (3) after reset: count 0 -> 1 -> 2 -> 3
    opcode = 6'd4;
    cyc("beq_fetch", E_FETCH);
    cyc("beq_decode", E_DECODE);
    cyc("beq_beq", E_BEQ);
    check("beq_count", {30'd0, instr_count}, 32'd1);
    opcode = 6'd13;
    cyc("ori_fetch", E_FETCH);
    cyc("ori_decode", E_DECODE);
    cyc("ori_oriex", E_ORIEX);
    cyc("ori_oriwb", E_ORIWB);
    check("ori_count", {30'd0, instr_count}, 32'd2);
    opcode = 6'd2;
    cyc("j_fetch", E_FETCH);
    cyc("j_decode", E_DECODE);
    cyc("j_jump", E_JUMP);
    check("j_count", {30'd0, instr_count}, 32'd3);
    cyc("j_back_to_fetch", E_FETCH);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS-lite main decoder: a Moore FSM that sequences one instruction over 3–5 cycles.
- Drives datapath mux selects and strobes per state.
- Supports R-type, lw, sw, beq, j, ori, bltzal, baln and jspal, with a parametrised opcode map.
- Adds a memory-ready stall handshake, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register's opcode field and the shared-memory multicycle datapath.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready treated as constant 1.
- OP_LW, 6'd35, lw opcode.
- OP_SW, 6'd43, sw opcode.
- OP_BEQ, 6'd4, beq opcode.
- OP_J, 6'd2, j opcode.
- OP_ORI, 6'd13, ori opcode.
- OP_BLTZAL, 6'd34, bltzal opcode.
- OP_JSPAL, 6'd19, jspal opcode.
- OP_BALN, 6'd27, baln opcode.
- Opcode 6'd0 is always R-type.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock domain only.
- opcode  in  6  instruction-register opcode field, stable from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load qualified by the datapath branch condition.
- brtype  out  2  branch condition: 00 zero (beq), 01 rs<0 (bltzal), 10 N flag (baln).
- pcsource  out  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target.
- iord  out  1  memory address source: 0 PC, 1 ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- memdata_link  out  1  memory write data is PC (link) instead of register B.
- irwrite  out  1  instruction register load.
- memtoreg  out  1  register write data from MDR.
- regdst  out  1  register destination: 1 rd, 0 rt.
- regwrite  out  1  register file write.
- linkwrite  out  1  write PC to $31.
- alusrca  out  1  ALU A input: 0 PC, 1 register A.
- alusrcb  out  2  ALU B input: 00 register B, 01 constant 4, 10 imm (sign- or zero-extended), 11 sign-extended imm<<2.
- zeroext  out  1  zero-extend immediate.
- aluop  out  2  00 add, 01 sub, 10 funct decode, 11 or.
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register and instr_count reset asynchronously to FETCH and 0.
- While reset is high, every strobe is forced to 0: pcwrite, pcwritecond, memread, memwrite, irwrite, regwrite, linkwrite, illegal_op. All selects output 0.
- Outputs are decoded combinationally from state. Unlisted outputs are 0 in every state.
- Let rdy = mem_ready when MEM_HANDSHAKE=1, else 1.
- State outputs and transitions:
  - FETCH: memread=1, alusrcb=01, aluop=00; irwrite=pcwrite=rdy. Hold in FETCH while !rdy, else go to DECODE.
  - DECODE: alusrcb=11, aluop=00. Next state by opcode:
    - R-type → EXEC
    - lw, sw, jspal → MEMADR
    - beq → BEQ
    - j → JUMP
    - ori → ORIEX
    - bltzal → BLTZ
    - baln → BALN
    - any other opcode: illegal_op=1 for this cycle, next state FETCH.
  - EXEC: alusrca=1, alusrcb=00, aluop=10 → RWB.
  - RWB: regdst=1, regwrite=1 → FETCH.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00 → MEMRD (lw), MEMWR (sw), JSPWR (jspal).
  - MEMRD: iord=1, memread=1. Hold while !rdy, else → MEMWB.
  - MEMWB: memtoreg=1, regwrite=1, regdst=0 → FETCH.
  - MEMWR: iord=1, memwrite=1. Hold while !rdy, else → FETCH.
  - JSPWR: iord=1, memwrite=1, memdata_link=1. Hold while !rdy, else → JUMP.
  - BEQ: alusrca=1, aluop=01, pcwritecond=1, brtype=00, pcsource=01 → FETCH.
  - BLTZ: alusrca=1, aluop=01, pcwritecond=1, brtype=01, pcsource=01, linkwrite=1 (unconditional link) → FETCH.
  - BALN: pcwritecond=1, brtype=10, pcsource=01, linkwrite=1 → FETCH.
  - JUMP: pcwrite=1, pcsource=10 → FETCH.
  - ORIEX: alusrca=1, alusrcb=10, zeroext=1, aluop=11 → ORIWB.
  - ORIWB: regwrite=1, regdst=0 → FETCH.
- Cycle counts with no stalls:
  - 3 cycles: beq, j, bltzal, baln.
  - 4 cycles: R-type, sw, ori.
  - 5 cycles: lw, jspal.
  - Each mem_ready-low cycle adds exactly one cycle.
- instr_count increments by 1 on each clock edge leaving a non-FETCH, non-DECODE state into FETCH. It wraps from 2^CNT_W−1 to 0. Illegal opcodes do not increment it.
- Write strobes are never high while the machine holds in a wait state, except the memwrite being retried in MEMWR/JSPWR.
- Unreachable state encodings go to FETCH on the next edge.
- Reset asserted mid-instruction aborts immediately with no further strobes. Execution resumes at FETCH on the first edge after deassertion.

Test Plan:
- R-type: MEM_HANDSHAKE=1, mem_ready=1, opcode=0 → states FETCH,DECODE,EXEC,RWB. regwrite=1 and regdst=1 only in cycle 4; instr_count 0→1.
- lw with memory stall: opcode=35, mem_ready low for 2 cycles in MEMRD → 7 cycles total. memread and iord held through MEMRD; regwrite+memtoreg exactly once.
- jspal: opcode=19 → MEMADR, JSPWR (memwrite=1, memdata_link=1), then JUMP (pcwrite=1, pcsource=10). 5 cycles.
- bltzal then baln: opcode=34 → BLTZ has pcwritecond=1, brtype=01, linkwrite=1. opcode=27 → brtype=10. 3 cycles each; count +2.
- Illegal opcode and FETCH stall: opcode=6'd63 → illegal_op high for exactly the DECODE cycle, return to FETCH, count unchanged. FETCH with mem_ready=0 for 3 cycles → irwrite=pcwrite=0 throughout.
- Reset and wrap: assert reset asynchronously in MEMWR → memwrite drops before the next edge, state=FETCH. With CNT_W=2, retire 5 instructions → instr_count=1.
